// File: rtl/alu_retire_unit.sv
// ALU result retire stage: evaluates the ARM condition against the architectural NZCV flags,
// registers passing results toward the register-file write port and updates the flags.
module alu_retire_unit #(
    parameter int REG_BITS = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_out,
    input  logic [3:0]          in_flags,
    input  logic [4:0]          in_uop,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                in_s,
    input  logic [3:0]          in_cond,
    input  logic                flags_wr_en,
    input  logic [3:0]          flags_wr,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [REG_BITS-1:0] wb_rd,
    output logic [31:0]         wb_data,
    output logic [3:0]          flags,
    output logic [CNT_BITS-1:0] retired_cnt,
    output logic [CNT_BITS-1:0] squashed_cnt
);

    localparam logic [4:0] UOP_CMP = 5'b00101;

    // ARM condition evaluation; flag order is Z, C, N, V from bit 0 upward.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic z;
        logic c;
        logic n;
        logic v;
        logic pass;
        z = f[0];
        c = f[1];
        n = f[2];
        v = f[3];
        case (cond)
            4'd0:    pass = z;
            4'd1:    pass = !z;
            4'd2:    pass = c;
            4'd3:    pass = !c;
            4'd4:    pass = n;
            4'd5:    pass = !n;
            4'd6:    pass = v;
            4'd7:    pass = !v;
            4'd8:    pass = c & !z;
            4'd9:    pass = !c | z;
            4'd10:   pass = (n == v);
            4'd11:   pass = (n != v);
            4'd12:   pass = !z & (n == v);
            4'd13:   pass = z | (n != v);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] cnt);
        logic [CNT_BITS-1:0] res;
        if (cnt == {CNT_BITS{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic accept_s;
    logic pass_s;
    logic is_cmp_s;
    logic retire_s;
    logic squash_s;
    logic wb_load_s;
    logic flag_load_s;

    // Handshake and retire decisions, all against the flags registered at the previous edge.
    always_comb begin
        in_ready    = !wb_valid | wb_ready;
        accept_s    = in_valid & in_ready;
        pass_s      = cond_pass(in_cond, flags);
        is_cmp_s    = (in_uop == UOP_CMP);
        retire_s    = accept_s & pass_s;
        squash_s    = accept_s & !pass_s;
        wb_load_s   = retire_s & !is_cmp_s;
        flag_load_s = retire_s & (in_s | is_cmp_s);
    end

    // One-entry write-back register; a new load replaces a draining entry without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= {REG_BITS{1'b0}};
            wb_data  <= 32'h0000_0000;
        end else if (wb_load_s) begin
            wb_valid <= 1'b1;
            wb_rd    <= in_rd;
            wb_data  <= in_out;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= wb_valid;
        end
    end

    // Architectural flags; the external write takes priority over an ALU update.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (flags_wr_en) begin
            flags <= flags_wr;
        end else if (flag_load_s) begin
            flags <= in_flags;
        end else begin
            flags <= flags;
        end
    end

    // Saturating retire and squash counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt  <= {CNT_BITS{1'b0}};
            squashed_cnt <= {CNT_BITS{1'b0}};
        end else begin
            if (retire_s) begin
                retired_cnt <= sat_inc(retired_cnt);
            end else begin
                retired_cnt <= retired_cnt;
            end
            if (squash_s) begin
                squashed_cnt <= sat_inc(squashed_cnt);
            end else begin
                squashed_cnt <= squashed_cnt;
            end
        end
    end

endmodule

// File: tb/tb_alu_retire_unit.sv
// Self-checking bench for alu_retire_unit: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the retire rules.
module tb_alu_retire_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_out;
    logic [3:0]  in_flags;
    logic [4:0]  in_uop;
    logic [3:0]  in_rd;
    logic        in_s;
    logic [3:0]  in_cond;
    logic        flags_wr_en;
    logic [3:0]  flags_wr;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags;
    logic [15:0] retired_cnt;
    logic [15:0] squashed_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_wb_valid;
    logic [3:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic [3:0]  m_flags;
    logic [15:0] m_ret;
    logic [15:0] m_sq;

    alu_retire_unit #(.REG_BITS(4), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_out(in_out), .in_flags(in_flags), .in_uop(in_uop), .in_rd(in_rd),
        .in_s(in_s), .in_cond(in_cond),
        .flags_wr_en(flags_wr_en), .flags_wr(flags_wr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .flags(flags), .retired_cnt(retired_cnt), .squashed_cnt(squashed_cnt)
    );

    always #5 clk = ~clk;

    // ARM conditions come in pairs: even code tests a predicate, odd code is its negation.
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit z, cy, n, v, base;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic cycle();
        bit acc, ok;
        acc = in_valid && (!m_wb_valid || wb_ready);
        ok  = m_cond(in_cond, m_flags);
        if (rst) begin
            m_wb_valid = 0; m_wb_rd = 4'h0; m_wb_data = 32'h0;
            m_flags = 4'h0; m_ret = 16'h0; m_sq = 16'h0;
        end else begin
            if (acc && ok && in_uop != 5'd5) begin
                m_wb_valid = 1; m_wb_rd = in_rd; m_wb_data = in_out;
            end else if (wb_ready) begin
                m_wb_valid = 0;
            end
            if (flags_wr_en) m_flags = flags_wr;
            else if (acc && ok && (in_s || in_uop == 5'd5)) m_flags = in_flags;
            if (acc && ok && m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            if (acc && !ok && m_sq != 16'hFFFF) m_sq = m_sq + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] uop, input logic [31:0] data,
                         input logic [3:0] fl, input logic [3:0] rd, input bit s,
                         input logic [3:0] cond);
        in_valid = v; in_uop = uop; in_out = data; in_flags = fl;
        in_rd = rd; in_s = s; in_cond = cond;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_ready = 1'b1; flags_wr_en = 1'b0; flags_wr = 4'h0;
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        cycle(); cycle();
        rst = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        checks++; if (wb_rd !== 4'h0 || wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb got rd=%h data=%h exp 0/0", wb_rd, wb_data); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
        checks++; if (retired_cnt !== 16'h0 || squashed_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", retired_cnt, squashed_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add();
        drive(1, 5'd1, 32'd5, 4'b0000, 4'd3, 1, 4'd14);
        cycle();
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd3 || wb_data !== 32'd5) begin errors++; $display("FAIL add_wb got v=%b rd=%h d=%h exp 1/3/5", wb_valid, wb_rd, wb_data); end
        checks++; if (flags !== 4'b0000 || retired_cnt !== 16'd1) begin errors++; $display("FAIL add_state got flags=%b ret=%0d exp 0000/1", flags, retired_cnt); end
    endtask

    task automatic test_cmp_cond();
        drive(1, 5'b00101, 32'd0, 4'b0001, 4'd9, 0, 4'd14);
        cycle();
        checks++; if (wb_valid !== 1'b0 || flags !== 4'b0001) begin errors++; $display("FAIL cmp got v=%b flags=%b exp 0/0001", wb_valid, flags); end
        drive(1, 5'd13, 32'd7, 4'b0000, 4'd2, 0, 4'd0);
        cycle();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd2 || wb_data !== 32'd7) begin errors++; $display("FAIL mov_eq got v=%b rd=%h d=%h exp 1/2/7", wb_valid, wb_rd, wb_data); end
        drive(1, 5'd13, 32'd8, 4'b0000, 4'd4, 0, 4'd1);
        cycle();
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        checks++; if (squashed_cnt !== 16'd1 || wb_valid !== 1'b0 || retired_cnt !== 16'd3) begin errors++; $display("FAIL mov_ne got sq=%0d v=%b ret=%0d exp 1/0/3", squashed_cnt, wb_valid, retired_cnt); end
    endtask

    task automatic test_stall();
        wb_ready = 1'b0;
        drive(1, 5'd13, 32'h0000_ABCD, 4'h0, 4'd5, 0, 4'd14);
        cycle();
        drive(1, 5'd13, 32'h0000_1234, 4'h0, 4'd6, 0, 4'd14);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 4'd5 || wb_data !== 32'h0000_ABCD) begin
                errors++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b rd=%h d=%h exp 0/1/5/abcd", i, in_ready, wb_valid, wb_rd, wb_data);
            end
            cycle();
        end
        wb_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready); end
        cycle();
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd6 || wb_data !== 32'h0000_1234) begin errors++; $display("FAIL stall_no_bubble got v=%b rd=%h d=%h exp 1/6/1234", wb_valid, wb_rd, wb_data); end
        cycle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", wb_valid); end
    endtask

    task automatic test_flags_wr();
        logic [15:0] ret_before;
        ret_before = retired_cnt;
        drive(1, 5'd2, 32'h55, 4'b1010, 4'd7, 1, 4'd14);
        flags_wr_en = 1'b1; flags_wr = 4'b0100;
        cycle();
        flags_wr_en = 1'b0;
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL flags_wr_prio got %b exp 0100", flags); end
        checks++; if (retired_cnt !== ret_before + 16'd1 || wb_valid !== 1'b1 || wb_data !== 32'h55) begin errors++; $display("FAIL flags_wr_retire got ret=%0d v=%b d=%h exp %0d/1/55", retired_cnt, wb_valid, wb_data, ret_before + 16'd1); end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] uop;
            uop = ($urandom_range(0, 3) == 0) ? 5'b00101 : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 9) < 7, uop, $urandom, 4'($urandom), 4'($urandom),
                  bit'($urandom_range(0, 1)), 4'($urandom));
            wb_ready    = $urandom_range(0, 9) < 7;
            flags_wr_en = $urandom_range(0, 7) == 0;
            flags_wr    = 4'($urandom);
            #1;
            checks++; if (in_ready !== (!m_wb_valid || wb_ready)) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", i, in_ready, !m_wb_valid || wb_ready); end
            cycle();
            checks++;
            if (wb_valid !== m_wb_valid || wb_rd !== m_wb_rd || wb_data !== m_wb_data || flags !== m_flags ||
                retired_cnt !== m_ret || squashed_cnt !== m_sq) begin
                errors++;
                $display("FAIL rnd_state[%0d] got v=%b rd=%h d=%h f=%b r=%0d s=%0d exp v=%b rd=%h d=%h f=%b r=%0d s=%0d",
                         i, wb_valid, wb_rd, wb_data, flags, retired_cnt, squashed_cnt,
                         m_wb_valid, m_wb_rd, m_wb_data, m_flags, m_ret, m_sq);
            end
        end
        flags_wr_en = 1'b0;
        wb_ready = 1'b1;
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        cycle();
    endtask

    task automatic test_reset_midstall();
        wb_ready = 1'b0;
        drive(1, 5'd1, 32'hDEAD, 4'b1111, 4'd1, 1, 4'd14);
        cycle();
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL midstall_setup got %b exp 1", wb_valid); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (wb_valid !== 1'b0 || flags !== 4'b0000 || in_ready !== 1'b1) begin errors++; $display("FAIL midstall_reset got v=%b f=%b rdy=%b exp 0/0000/1", wb_valid, flags, in_ready); end
        checks++; if (retired_cnt !== 16'h0 || squashed_cnt !== 16'h0) begin errors++; $display("FAIL midstall_cnt got %h/%h exp 0/0", retired_cnt, squashed_cnt); end
        wb_ready = 1'b1;
    endtask

    task automatic test_saturate();
        drive(1, 5'd1, 32'h1, 4'h0, 4'd1, 0, 4'd14);
        for (int i = 0; i < 70000 && m_ret != 16'hFFFE; i++) cycle();
        checks++; if (retired_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", retired_cnt); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (retired_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold[%0d] got %h exp ffff", i, retired_cnt); end
        end
        drive(0, 5'd0, 32'h0, 4'h0, 4'h0, 0, 4'd14);
        cycle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp_cond();
        test_stall();
        test_flags_wr();
        test_random();
        test_reset_midstall();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
